// File: rtl/regfile_wb.sv
// Architectural 32x32 register file with writeback commit and per-register in-flight write scoreboard.
// Latency: reads, bypass and hazard are combinational; commits and scoreboard updates land at the next clk edge.
// Backpressure: hazard stalls decode; an issue presented while hazard is high is ignored and must be re-presented.
// Optional build macro REGFILE_BYPASS_EN: forwards same-cycle writeback data to reads and resolves the hazard early.
module regfile_wb #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        rs1_used,
  input  logic        rs2_used,
  output logic [31:0] rD1,
  output logic [31:0] rD2,
  input  logic        iss_valid,
  input  logic        iss_we,
  input  logic [4:0]  iss_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wD,
  output logic        hazard,
  output logic        sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // x0 is hardwired, so storage and counters start at index 1
  logic [31:0]      regs_q [1:31];
  logic [31:0]      regs_d [1:31];
  logic [CNT_W-1:0] cnt_q  [1:31];
  logic [CNT_W-1:0] cnt_d  [1:31];
  logic             sb_err_q, sb_err_d;

  logic             inc, dec;
  logic [CNT_W-1:0] cnt1, cnt2;
  logic [31:0]      sto1, sto2;
  logic             resolved1, resolved2;
  logic             hazard1, hazard2;

  assign dec = wb_we && (wb_rd != 5'd0);

  // Look up stored value and pending count for both read ports; index 0 falls through to zero
  always_comb begin
    cnt1 = '0;
    cnt2 = '0;
    sto1 = '0;
    sto2 = '0;
    for (int r = 1; r < 32; r++) begin
      if (rs1 == 5'(r)) begin
        cnt1 = cnt_q[r];
        sto1 = regs_q[r];
      end
      if (rs2 == 5'(r)) begin
        cnt2 = cnt_q[r];
        sto2 = regs_q[r];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A writeback in flight this cycle is forwarded; it clears the hazard only when it is the last pending write
  assign resolved1 = dec && (wb_rd == rs1) && (cnt1 == CNT_ONE);
  assign resolved2 = dec && (wb_rd == rs2) && (cnt2 == CNT_ONE);
  assign rD1       = (dec && (wb_rd == rs1)) ? wD : sto1;
  assign rD2       = (dec && (wb_rd == rs2)) ? wD : sto2;
`else
  // Reads see storage only, so a dependent read waits until the cycle after writeback
  assign resolved1 = 1'b0;
  assign resolved2 = 1'b0;
  assign rD1       = sto1;
  assign rD2       = sto2;
`endif

  assign hazard1 = rs1_used && (rs1 != 5'd0) && (cnt1 != '0) && !resolved1;
  assign hazard2 = rs2_used && (rs2 != 5'd0) && (cnt2 != '0) && !resolved2;
  assign hazard  = hazard1 | hazard2;
  assign sb_err  = sb_err_q;

  // A stalled issue must not touch the scoreboard
  assign inc = iss_valid && !hazard && iss_we && (iss_rd != 5'd0);

  // Next-state for storage, saturating counters and the sticky error flag
  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    for (int r = 1; r < 32; r++) begin
      if (dec && (wb_rd == 5'(r))) begin
        regs_d[r] = wD;
      end
      if (inc && (iss_rd == 5'(r)) && !(dec && (wb_rd == 5'(r)))) begin
        if (cnt_q[r] == CNT_MAX) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end
      if (dec && (wb_rd == 5'(r)) && !(inc && (iss_rd == 5'(r)))) begin
        if (cnt_q[r] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
  end

  // State registers; reset wins over any same-cycle commit or issue
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb using an expectation queue.
// Expectations are queued as stimulus is applied and drained once outputs settle.
// Works for both builds; bypass-dependent expectations follow REGFILE_BYPASS_EN.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2;
  logic        rs1_used, rs2_used;
  logic [31:0] rD1, rD2;
  logic        iss_valid, iss_we;
  logic [4:0]  iss_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wD;
  logic        hazard, sb_err;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int S_RD1 = 0, S_RD2 = 1, S_HAZ = 2, S_ERR = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_wb #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rD1(rD1), .rD2(rD2),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wD(wD),
    .hazard(hazard), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input int sel, input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sbq.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #2;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        S_RD1:   obs = rD1;
        S_RD2:   obs = rD2;
        S_HAZ:   obs = {31'd0, hazard};
        default: obs = {31'd0, sb_err};
      endcase
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0;
    wb_we = 1'b0; wb_rd = '0; wD = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = rd;
    tick();
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [31:0] d);
    idle();
    wb_we = 1'b1; wb_rd = rd; wD = d;
    tick();
  endtask

  initial begin
    idle();
    // Reset overrides a same-cycle writeback and issue
    rst = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd1; wD = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd2;
    tick();
    tick();
    idle();
    rs1 = 5'd1; rs2 = 5'd2; rs2_used = 1'b1;
    expect_out(S_RD1, "rst_blocks_commit", 32'd0);
    expect_out(S_HAZ, "rst_blocks_issue", 32'd0);
    expect_out(S_ERR, "rst_sb_err", 32'd0);
    drain();

    // Every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      idle();
      rs1 = 5'(i); rs2 = 5'(31 - i); rs1_used = 1'b1; rs2_used = 1'b1;
      expect_out(S_RD1, $sformatf("rst_rd1_x%0d", i), 32'd0);
      expect_out(S_RD2, $sformatf("rst_rd2_x%0d", 31 - i), 32'd0);
      expect_out(S_HAZ, "rst_hazard", 32'd0);
      drain();
    end

    // Writes to x0 are dropped and are not a scoreboard underflow
    idle();
    wb_we = 1'b1; wb_rd = 5'd0; wD = 32'hDEAD_BEEF;
    expect_out(S_RD1, "x0_wb_cycle", 32'd0);
    drain();
    tick();
    idle();
    expect_out(S_RD1, "x0_after_wb", 32'd0);
    expect_out(S_ERR, "x0_no_err", 32'd0);
    drain();

    // RAW on x5; a stalled issue to x6 must not be recorded
    issue(5'd5);
    idle();
    rs1 = 5'd5; rs1_used = 1'b1;
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd6;
    expect_out(S_HAZ, "x5_hazard", 32'd1);
    expect_out(S_RD1, "x5_old", 32'd0);
    drain();
    tick();
    idle();
    rs1 = 5'd5; rs1_used = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd5; wD = 32'h1234_5678;
    expect_out(S_RD1, "x5_wb_cycle_data", BYP ? 32'h1234_5678 : 32'd0);
    expect_out(S_HAZ, "x5_wb_cycle_hazard", BYP ? 32'd0 : 32'd1);
    drain();
    tick();
    idle();
    rs1 = 5'd5; rs1_used = 1'b1; rs2 = 5'd6; rs2_used = 1'b1;
    expect_out(S_RD1, "x5_after_wb", 32'h1234_5678);
    expect_out(S_HAZ, "x5_x6_clear", 32'd0);
    expect_out(S_ERR, "x5_no_err", 32'd0);
    drain();

    // Simultaneous issue and writeback to x7 keeps its count at one
    issue(5'd7);
    idle();
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd7;
    wb_we = 1'b1; wb_rd = 5'd7; wD = 32'h0000_0077;
    tick();
    idle();
    rs2 = 5'd7; rs2_used = 1'b1;
    expect_out(S_HAZ, "x7_still_pending", 32'd1);
    expect_out(S_RD2, "x7_committed", 32'h0000_0077);
    drain();
    idle();
    rs2 = 5'd7; rs2_used = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd7; wD = 32'h0000_0078;
    expect_out(S_HAZ, "x7_last_wb_hazard", BYP ? 32'd0 : 32'd1);
    expect_out(S_RD2, "x7_last_wb_data", BYP ? 32'h0000_0078 : 32'h0000_0077);
    drain();
    tick();
    idle();
    rs2 = 5'd7; rs2_used = 1'b1;
    expect_out(S_HAZ, "x7_clear", 32'd0);
    expect_out(S_ERR, "x7_no_err", 32'd0);
    drain();

    // Unused source does not stall
    issue(5'd4);
    idle();
    rs1 = 5'd4;
    expect_out(S_HAZ, "x4_unused", 32'd0);
    drain();
    rs1_used = 1'b1;
    expect_out(S_HAZ, "x4_used", 32'd1);
    drain();

    // Overflow on x3: count saturates at 3, error is sticky
    issue(5'd3);
    issue(5'd3);
    issue(5'd3);
    idle();
    rs1 = 5'd3; rs1_used = 1'b1;
    expect_out(S_HAZ, "x3_pending", 32'd1);
    expect_out(S_ERR, "x3_before_ovf", 32'd0);
    drain();
    idle();
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd3;
    expect_out(S_HAZ, "x3_ovf_issue_hazard", 32'd0);
    drain();
    tick();
    idle();
    expect_out(S_ERR, "x3_ovf_err", 32'd1);
    drain();
    writeback(5'd3, 32'h0000_0031);
    writeback(5'd3, 32'h0000_0032);
    idle();
    rs1 = 5'd3; rs1_used = 1'b1;
    expect_out(S_HAZ, "x3_one_left", 32'd1);
    expect_out(S_RD1, "x3_second_wb", 32'h0000_0032);
    drain();
    writeback(5'd3, 32'h0000_0033);
    idle();
    rs1 = 5'd3; rs1_used = 1'b1;
    expect_out(S_HAZ, "x3_drained", 32'd0);
    expect_out(S_ERR, "x3_err_sticky", 32'd1);
    drain();
    tick();
    tick();
    expect_out(S_ERR, "x3_err_still_sticky", 32'd1);
    drain();

    // Only reset clears the error; reset also clears pending x4
    idle();
    rst = 1'b1;
    tick();
    idle();
    rs1 = 5'd4; rs1_used = 1'b1; rs2 = 5'd5;
    expect_out(S_ERR, "err_cleared_by_rst", 32'd0);
    expect_out(S_HAZ, "x4_cleared_by_rst", 32'd0);
    expect_out(S_RD2, "x5_cleared_by_rst", 32'd0);
    drain();

    // Underflow on x9: data still committed, count stays at zero
    writeback(5'd9, 32'hA5A5_A5A5);
    idle();
    rs1 = 5'd9; rs1_used = 1'b1;
    expect_out(S_RD1, "x9_underflow_data", 32'hA5A5_A5A5);
    expect_out(S_ERR, "x9_underflow_err", 32'd1);
    expect_out(S_HAZ, "x9_count_held_zero", 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
